// File: rtl/processor_pkg.sv
// processor_pkg: interrupt FSM states and memory-stage write-data selector codes,
// shared with the Memory_Stage write-data mux.
package processor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PUSH_HI,
        PUSH_LO,
        PUSH_FL,
        VECTOR,
        IN_ISR
    } int_state_t;

    localparam logic [1:0] SEL_NORMAL = 2'b00;
    localparam logic [1:0] SEL_PC_HI  = 2'b01;
    localparam logic [1:0] SEL_PC_LO  = 2'b10;
    localparam logic [1:0] SEL_FLAGS  = 2'b11;

    function automatic logic [1:0] push_sel(input int_state_t s);
        return s == PUSH_HI ? SEL_PC_HI :
               s == PUSH_LO ? SEL_PC_LO :
               s == PUSH_FL ? SEL_FLAGS : SEL_NORMAL;
    endfunction

endpackage

// File: rtl/int_req_detect.sv
// int_req_detect: rising-edge detect on the level request plus a one-deep pending
// latch that remembers an edge arriving while an interrupt is already being served.
module int_req_detect (
    input  logic clk,
    input  logic reset,
    input  logic int_req,
    input  logic clear,
    input  logic busy,
    output logic req_edge,
    output logic pending
);

    logic int_req_q;

    assign req_edge = int_req & ~int_req_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_req_q <= 1'b0;
            pending   <= 1'b0;
        end else begin
            int_req_q <= int_req;
            pending   <= clear ? 1'b0 : pending | (req_edge & busy);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: drains the pipeline on a request, pushes PC hi/lo and flags
// through the memory stage, redirects fetch to the vector and blocks nesting until rti.
module interrupt_controller
    import processor_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] VECTOR_ADDR  = 32'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic [31:0] fetch_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        pipe_stall,
    input  logic        rti,
    output logic        if_stall,
    output logic        int_mem_selector1,
    output logic        int_mem_selector2,
    output logic        stack_push,
    output logic        interrupt,
    output logic [31:0] int_pc,
    output logic [31:0] saved_pc,
    output logic        in_isr
);

    localparam int            CW       = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

    int_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic          req_edge, pending, start, drain_done;

    int_req_detect u_detect (
        .clk      (clk),
        .reset    (reset),
        .int_req  (int_req),
        .clear    (state == IDLE),
        .busy     (state != IDLE),
        .req_edge (req_edge),
        .pending  (pending)
    );

    assign start      = state == IDLE && (req_edge || pending);
    assign drain_done = state == DRAIN && !pipe_stall && cnt == CNT_LAST;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? DRAIN : IDLE;
            DRAIN:   state_nxt = drain_done ? PUSH_HI : DRAIN;
            PUSH_HI: state_nxt = PUSH_LO;
            PUSH_LO: state_nxt = PUSH_FL;
            PUSH_FL: state_nxt = VECTOR;
            VECTOR:  state_nxt = IN_ISR;
            IN_ISR:  state_nxt = rti ? IDLE : IN_ISR;
            default: state_nxt = IDLE;
        endcase
    end

    // The last redirect seen in DRAIN, including the final cycle, is the resume PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            saved_pc <= '0;
        end else if (start) begin
            cnt      <= '0;
            saved_pc <= fetch_pc;
        end else if (state == DRAIN) begin
            if (!pipe_stall)
                cnt <= cnt + CW'(1);
            if (redirect_valid)
                saved_pc <= redirect_pc;
        end
    end

    always_comb begin
        {int_mem_selector2, int_mem_selector1} = push_sel(state);
        stack_push = state inside {PUSH_HI, PUSH_LO, PUSH_FL};
        if_stall   = state inside {DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, VECTOR};
        interrupt  = state == VECTOR;
        int_pc     = state == VECTOR ? VECTOR_ADDR : 32'h0;
        in_isr     = state == IN_ISR;
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed stimulus with a scoreboard of expected push/vector
// beats, popped and compared by a monitor whenever the DUT pushes or vectors.
module tb_interrupt_controller;

    localparam int D = 3;

    typedef struct {
        int          cyc;
        logic [1:0]  sel;
        logic        push;
        logic        intr;
        logic [31:0] ipc;
        logic [31:0] spc;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b0, int_req = 1'b0;
    logic        redirect_valid = 1'b0, pipe_stall = 1'b0, rti = 1'b0;
    logic [31:0] fetch_pc = 32'h0, redirect_pc = 32'h0;
    logic        if_stall, int_mem_selector1, int_mem_selector2, stack_push, interrupt, in_isr;
    logic [31:0] int_pc, saved_pc;

    int   cyc = 0, checks = 0, errors = 0, stall_cnt = 0;
    exp_t q[$];

    interrupt_controller #(.DRAIN_CYCLES(D), .VECTOR_ADDR(32'd16)) dut (
        .clk               (clk),
        .reset             (reset),
        .int_req           (int_req),
        .fetch_pc          (fetch_pc),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .pipe_stall        (pipe_stall),
        .rti               (rti),
        .if_stall          (if_stall),
        .int_mem_selector1 (int_mem_selector1),
        .int_mem_selector2 (int_mem_selector2),
        .stack_push        (stack_push),
        .interrupt         (interrupt),
        .int_pc            (int_pc),
        .saved_pc          (saved_pc),
        .in_isr            (in_isr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        stall_cnt <= stall_cnt + int'(if_stall);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_if_stall"}, 32'(if_stall), 32'd0);
        chk({p, "_sel"}, 32'({int_mem_selector2, int_mem_selector1}), 32'd0);
        chk({p, "_stack_push"}, 32'(stack_push), 32'd0);
        chk({p, "_interrupt"}, 32'(interrupt), 32'd0);
        chk({p, "_int_pc"}, int_pc, 32'd0);
        chk({p, "_saved_pc"}, saved_pc, 32'd0);
        chk({p, "_in_isr"}, 32'(in_isr), 32'd0);
    endtask

    // Request sampled at the posedge ending cycle c: DRAIN from c+1, pushes after D+st cycles.
    task automatic exp_seq(input int c, input int st, input logic [31:0] pc);
        for (int k = 0; k < 3; k++)
            q.push_back('{c + D + 1 + st + k, 2'(k + 1), 1'b1, 1'b0, 32'h0, pc});
        q.push_back('{c + D + 4 + st, 2'b00, 1'b0, 1'b1, 32'h10, pc});
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset && (stack_push || interrupt)) begin
            exp_t e;
            if (q.size() == 0) begin
                chk("unexpected_beat", {30'b0, stack_push, interrupt}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("beat_cycle", cyc, e.cyc);
                chk("beat_sel", 32'({int_mem_selector2, int_mem_selector1}), 32'(e.sel));
                chk("beat_stack_push", 32'(stack_push), 32'(e.push));
                chk("beat_interrupt", 32'(interrupt), 32'(e.intr));
                chk("beat_int_pc", int_pc, e.ipc);
                chk("beat_saved_pc", saved_pc, e.spc);
            end
        end
    end

    initial begin
        int s0;
        at(1);
        chk_zero("reset");
        at(2); reset = 1'b1; s0 = stall_cnt; fetch_pc = 32'h0000_1234;
        // basic service
        at(5); int_req = 1'b1; exp_seq(5, 0, 32'h0000_1234);
        at(6); int_req = 1'b0;
        at(8); chk("drain_if_stall", 32'(if_stall), 32'd1);
        at(13);
        chk("basic_in_isr", 32'(in_isr), 32'd1);
        chk("basic_isr_if_stall", 32'(if_stall), 32'd0);
        chk("basic_stall_len", stall_cnt - s0, D + 4);
        redirect_valid = 1'b1; redirect_pc = 32'hdead_beef;
        at(14); redirect_valid = 1'b0; rti = 1'b1;
        at(15); rti = 1'b0;
        chk("basic_rti_idle", 32'(in_isr), 32'd0);
        chk("redirect_outside_drain", saved_pc, 32'h0000_1234);
        // redirect in the middle of drain
        at(20); fetch_pc = 32'h0000_2000; int_req = 1'b1; exp_seq(20, 0, 32'h0000_0400);
        at(21); int_req = 1'b0;
        at(22); redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        at(23); redirect_valid = 1'b0;
        at(28); chk("redir_in_isr", 32'(in_isr), 32'd1); rti = 1'b1;
        at(29); rti = 1'b0;
        // pipe_stall for two drain cycles
        at(35); fetch_pc = 32'h0000_3000; int_req = 1'b1; exp_seq(35, 2, 32'h0000_3000); s0 = stall_cnt;
        at(36); int_req = 1'b0; pipe_stall = 1'b1;
        at(38); pipe_stall = 1'b0;
        at(45);
        chk("stall_len", stall_cnt - s0, D + 6);
        chk("stall_in_isr", 32'(in_isr), 32'd1);
        rti = 1'b1;
        at(46); rti = 1'b0;
        // pending edge during ISR, third edge dropped
        at(50); fetch_pc = 32'h0000_5000; int_req = 1'b1; exp_seq(50, 0, 32'h0000_5000);
        at(51); int_req = 1'b0;
        at(59); int_req = 1'b1;
        at(60); int_req = 1'b0;
        at(61); int_req = 1'b1;
        at(62); int_req = 1'b0; fetch_pc = 32'h0000_6000;
        at(64); rti = 1'b1;
        at(65); rti = 1'b0;
        chk("pend_idle_if_stall", 32'(if_stall), 32'd0);
        chk("pend_idle_in_isr", 32'(in_isr), 32'd0);
        exp_seq(65, 0, 32'h0000_6000);
        at(66); chk("pend_drain_if_stall", 32'(if_stall), 32'd1);
        at(73); chk("pend_in_isr", 32'(in_isr), 32'd1); rti = 1'b1;
        at(74); rti = 1'b0;
        at(85);
        chk("third_edge_dropped_stall", 32'(if_stall), 32'd0);
        chk("third_edge_dropped_isr", 32'(in_isr), 32'd0);
        // latest redirect wins, including one in the final drain cycle
        at(90); fetch_pc = 32'h0000_7000; int_req = 1'b1; exp_seq(90, 0, 32'h0001_0500);
        at(91); int_req = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        at(92); redirect_valid = 1'b0;
        at(93); redirect_valid = 1'b1; redirect_pc = 32'h0001_0500;
        at(94); redirect_valid = 1'b0;
        at(98); chk("final_redir_in_isr", 32'(in_isr), 32'd1); rti = 1'b1;
        at(99); rti = 1'b0;
        // level held 50 cycles gives one service; stray rti in IDLE ignored
        at(105); fetch_pc = 32'h0000_8000; int_req = 1'b1; exp_seq(105, 0, 32'h0000_8000);
        at(113); chk("level_in_isr", 32'(in_isr), 32'd1); rti = 1'b1;
        at(114); rti = 1'b0;
        at(120); rti = 1'b1;
        at(121); rti = 1'b0;
        at(122);
        chk("stray_rti_if_stall", 32'(if_stall), 32'd0);
        chk("stray_rti_in_isr", 32'(in_isr), 32'd0);
        at(155); int_req = 1'b0;
        // reset during PUSH_LO with a pending edge queued
        at(165); fetch_pc = 32'h0000_9000; int_req = 1'b1; exp_seq(165, 0, 32'h0000_9000);
        at(166); int_req = 1'b0;
        at(167); int_req = 1'b1;
        at(168); int_req = 1'b0;
        at(170);
        #2 reset = 1'b0;
        #1 chk_zero("midpush_reset");
        q.delete();
        at(172); reset = 1'b1; s0 = stall_cnt;
        at(185);
        chk("pending_lost_stall", stall_cnt - s0, 32'd0);
        chk("pending_lost_isr", 32'(in_isr), 32'd0);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Single-level interrupt controller sitting beside the fetch stage and feeding both the fetch PC mux and the memory stage. It detects an external interrupt request, freezes fetch while in-flight instructions drain, then steers the memory stage through three stack pushes: PC high, PC low, flags. Finally it redirects fetch to a fixed vector and holds off further interrupts until the handler returns.

## Interface
- DRAIN_CYCLES, 3: cycles fetch is frozen before pushing, enough for ID/EX/MEM to retire (≥1).
- VECTOR_ADDR, 32'd16: handler entry PC driven to the fetch mux.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- int_req  in  1  external request, level, synchronous to clk; rising edge requests service.
- fetch_pc  in  32  PC of the next instruction fetch would issue.
- redirect_valid  in  1  branch/jump/return resolved this cycle.
- redirect_pc  in  32  target of that redirect.
- pipe_stall  in  1  hazard stall; freezes drain counter.
- rti  in  1  one-cycle pulse from decode: handler return retired.
- if_stall  out  1  freeze PC and IF/ID buffer.
- int_mem_selector1  out  1  memory-stage write-data select, bit 0.
- int_mem_selector2  out  1  memory-stage write-data select, bit 1.
- stack_push  out  1  memory stage writes at SP and decrements SP.
- interrupt  out  1  one-cycle pulse: fetch mux loads int_pc.
- int_pc  out  32  VECTOR_ADDR while interrupt is high, else 0.
- saved_pc  out  32  resume PC that will be pushed.
- in_isr  out  1  handler executing.

## Operation
- States: IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, VECTOR, IN_ISR.
- Edge detect: req_edge = int_req & ~int_req_q; int_req_q is registered.
- IDLE: on req_edge or pending → DRAIN. Load saved_pc ← fetch_pc, clear pending, counter ← 0.
- DRAIN:
  - Counter increments each cycle pipe_stall=0 and holds when pipe_stall=1.
  - redirect_valid → saved_pc ← redirect_pc. The latest redirect wins.
  - When counter = DRAIN_CYCLES-1 and pipe_stall=0 → PUSH_HI.
- PUSH_HI: {sel2,sel1}=2'b01 (saved_pc[31:16]), stack_push=1 → PUSH_LO.
- PUSH_LO: {sel2,sel1}=2'b10 (saved_pc[15:0]), stack_push=1 → PUSH_FL.
- PUSH_FL: {sel2,sel1}=2'b11 (flags), stack_push=1 → VECTOR.
- VECTOR: interrupt=1, int_pc=VECTOR_ADDR → IN_ISR.
- IN_ISR: in_isr=1. rti → IDLE.
- Outside PUSH_*, selectors are 00 (normal datapath) and stack_push=0.
- if_stall=1 in DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, VECTOR; 0 in IDLE and IN_ISR.
- No nesting: a req_edge in any state other than IDLE sets pending (one-deep; further edges are lost). Pending is served on the first IDLE cycle after rti.
- rti outside IN_ISR is ignored.
- redirect_valid outside DRAIN never changes saved_pc.

## Timing
- Reset (async assert): state=IDLE, pending=0, int_req_q=0, counter=0, saved_pc=0. Every output is 0.
- Moore outputs only, decoded from the state register; no input→output combinational path.
- Edge sampled at posedge k → DRAIN from k+1. With no pipe_stall, PUSH_HI starts at k+1+DRAIN_CYCLES.
- The interrupt pulse follows 3 cycles after PUSH_HI starts.
- Total if_stall length = DRAIN_CYCLES+4 cycles, plus one per pipe_stall cycle in DRAIN.
- A redirect in the final DRAIN cycle is still captured before PUSH_HI.
- rti at posedge m → IDLE at m+1. If pending, DRAIN at m+2.
- Reset mid-sequence aborts immediately: pushes already issued are not undone, and pending is lost.

## Structure
- Shared package processor_pkg:
  - state enum int_state_t.
  - selector constants SEL_NORMAL=2'b00, SEL_PC_HI=2'b01, SEL_PC_LO=2'b10, SEL_FLAGS=2'b11.
  - the Memory_Stage write-data mux uses the same constants.
- Sub-module int_req_detect: edge register plus pending latch, with inputs int_req, clear, busy. Everything else lives in one FSM module.
- Counter width: $clog2(DRAIN_CYCLES+1).

## Test plan
- Basic: DRAIN_CYCLES=3, fetch_pc=0x0000_1234, int_req rises at cycle 5.
  - if_stall high cycles 6–12.
  - stack_push high cycles 9–11, with selectors 01, 10, 11 in that order; saved_pc=0x1234.
  - interrupt high at cycle 12 with int_pc=0x10; in_isr high from cycle 13.
- Redirect during drain: redirect_valid with redirect_pc=0x0000_0400 at cycle 7 → 0x0400 is pushed (hi 0x0000, lo 0x0400).
- pipe_stall during drain: pipe_stall held 2 cycles in DRAIN → PUSH_HI and interrupt each arrive 2 cycles later.
- Pending request: int_req rises again during IN_ISR, then rti at cycle 30.
  - IDLE at 31, DRAIN at 32; a second full push sequence follows.
  - A third edge in IN_ISR is dropped.
- Level hold and stray rti:
  - int_req held high for 50 cycles → exactly one service.
  - rti pulsed in IDLE → no state change.
- Reset mid-push: reset low during PUSH_LO → all outputs 0 asynchronously; IDLE after release; pending=0.
